// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing at clk/BAUD_DIV bit rate, fed through a small
// byte FIFO so producers are decoupled from the serial line rate.
module uart_tx #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_100M,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_byte,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        shifter;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;

  logic push;
  logic pop;
  logic baud_wrap;
  logic can_start;

  // Ready and busy come straight from registered state, never from inputs.
  assign tx_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign tx_busy    = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  assign push      = tx_valid && tx_ready;
  assign baud_wrap = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
  assign can_start = en && (count != '0);
  // A frame may start from IDLE, or back-to-back at the end of a stop bit.
  assign pop       = can_start && ((state == IDLE) || ((state == STOP) && baud_wrap));

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_100M) begin
    if (push) begin
      mem[wr_ptr] <= tx_byte;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; tx is its own register and only changes at bit boundaries.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shifter  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shifter <= mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shifter <= {1'b0, shifter[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (pop) begin
              shifter <= mem[rd_ptr];
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: timestamp-based line model plus directed and random traffic.
module tb_uart_tx;

  localparam int BAUD  = 20;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk_100M = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model state: queued bytes, and the edge index at which the current frame began.
  logic [7:0] mq[$];
  bit         m_in_frame = 1'b0;
  int         m_start    = 0;
  int         m_edges    = 0;
  logic [7:0] m_byte     = 8'h00;
  logic       m_tx       = 1'b1;
  logic       m_ready    = 1'b1;
  logic       m_busy     = 1'b0;
  logic [31:0] m_count   = 32'd0;

  logic [7:0] rb;
  int         ta;
  int         tb2;

  uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .en         (en),
    .tx_valid   (tx_valid),
    .tx_byte    (tx_byte),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk_100M = ~clk_100M;

  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line model: a frame is 10 slots of BAUD edges starting at the pop edge.
  task automatic model_step();
    int  e;
    int  idx;
    bit  room;
    e = 0;
    if (rst) begin
      mq.delete();
      m_in_frame = 1'b0;
      m_edges    = 0;
      m_start    = 0;
    end else begin
      e    = m_edges;
      room = (mq.size() != DEPTH);
      if (!m_in_frame || (e - m_start) == FRAME) begin
        if (en && mq.size() != 0) begin
          m_byte     = mq.pop_front();
          m_start    = e;
          m_in_frame = 1'b1;
        end else begin
          m_in_frame = 1'b0;
        end
      end
      if (tx_valid && room) mq.push_back(tx_byte);
      m_edges = e + 1;
    end
    if (m_in_frame) begin
      idx = (e - m_start) / BAUD;
      if (idx == 0)      m_tx = 1'b0;
      else if (idx == 9) m_tx = 1'b1;
      else               m_tx = m_byte[idx-1];
    end else begin
      m_tx = 1'b1;
    end
    m_count = 32'(mq.size());
    m_ready = (mq.size() != DEPTH);
    m_busy  = m_in_frame || (mq.size() != 0);
  endtask

  initial forever begin
    @(posedge clk_100M or posedge rst);
    model_step();
  end

  // Every falling edge: all outputs against the model.
  initial forever begin
    @(negedge clk_100M);
    chk("tx", 32'(tx), 32'(m_tx));
    chk("tx_ready", 32'(tx_ready), 32'(m_ready));
    chk("tx_busy", 32'(tx_busy), 32'(m_busy));
    chk("fifo_count", 32'(fifo_count), m_count);
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(posedge clk_100M);
    #1;
    tx_valid = 1'b0;
    tx_byte  = 8'($urandom);
  endtask

  // Serial decoder: find the start bit, then sample each bit near its middle.
  task automatic rx_frame(output logic [7:0] b, output int t0);
    logic [9:0] bits;
    bit seen;
    seen = 1'b0;
    bits = '0;
    b    = 8'hxx;
    t0   = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk_100M);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_timeout: no start bit within %0d cycles", 3 * FRAME);
    end else begin
      t0 = cyc;
      repeat (BAUD / 2) @(negedge clk_100M);
      bits[0] = tx;
      for (int k = 1; k < 10; k++) begin
        repeat (BAUD) @(negedge clk_100M);
        bits[k] = tx;
      end
      chk("rx_start_bit", 32'(bits[0]), 32'd0);
      chk("rx_stop_bit", 32'(bits[9]), 32'd1);
      b = bits[8:1];
    end
    @(posedge clk_100M);
    #1;
  endtask

  task automatic rx_expect(input string name, input logic [7:0] exp);
    logic [7:0] b;
    int t;
    rx_frame(b, t);
    chk(name, 32'(b), 32'(exp));
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] d6 [5];
    int rate;

    // Reset state
    step(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    step(2);

    // 1: single 0x55 frame, latency, mid-bit pattern, busy duration
    pat = 10'b1010101010;
    push(8'h55);
    @(negedge clk_100M);
    chk("t1_before_fall", 32'(tx), 32'd1);
    @(negedge clk_100M);
    chk("t1_fall", 32'(tx), 32'd0);
    repeat (BAUD / 2) @(negedge clk_100M);
    chk("t1_bit0", 32'(tx), 32'(pat[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (BAUD) @(negedge clk_100M);
      chk("t1_bit", 32'(tx), 32'(pat[k]));
    end
    repeat (BAUD / 2 - 1) @(negedge clk_100M);
    chk("t1_busy_last", 32'(tx_busy), 32'd1);
    @(negedge clk_100M);
    chk("t1_busy_fall", 32'(tx_busy), 32'd0);
    @(posedge clk_100M);
    #1;
    step(5);

    // 2: back-to-back frames with no idle gap
    push(8'hA3);
    push(8'h0F);
    rx_frame(rb, ta);
    chk("t2_byte0", 32'(rb), 32'h0000_00A3);
    rx_frame(rb, tb2);
    chk("t2_byte1", 32'(rb), 32'h0000_000F);
    chk("t2_gap", 32'(tb2 - ta), 32'(FRAME));
    step(FRAME);

    // 3: overfill while disabled
    en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h11 * (i + 1)));
    step(3);
    chk("t3_count", 32'(fifo_count), 32'd4);
    chk("t3_ready", 32'(tx_ready), 32'd0);
    chk("t3_tx_idle", 32'(tx), 32'd1);
    en = 1'b1;
    rx_expect("t3_byte0", 8'h11);
    rx_expect("t3_byte1", 8'h22);
    rx_expect("t3_byte2", 8'h33);
    rx_expect("t3_byte3", 8'h44);
    step(FRAME);
    chk("t3_drained", 32'(fifo_count), 32'd0);

    // 4: drop en mid-frame with two bytes queued
    push(8'hC6);
    push(8'h39);
    push(8'h5A);
    fork
      rx_frame(rb, ta);
      begin
        step(4 * BAUD);
        en = 1'b0;
      end
    join
    chk("t4_byte0", 32'(rb), 32'h0000_00C6);
    step(2 * BAUD);
    chk("t4_tx_held", 32'(tx), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd2);
    chk("t4_busy", 32'(tx_busy), 32'd1);
    en = 1'b1;
    rx_expect("t4_byte1", 8'h39);
    rx_expect("t4_byte2", 8'h5A);
    step(FRAME);

    // 5: asynchronous reset in the middle of a data bit
    push(8'h00);
    push(8'h7E);
    step(4 * BAUD);
    chk("t5_pre_tx", 32'(tx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_tx", 32'(tx), 32'd1);
    chk("t5_async_count", 32'(fifo_count), 32'd0);
    chk("t5_async_ready", 32'(tx_ready), 32'd1);
    chk("t5_async_busy", 32'(tx_busy), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    push(8'h81);
    rx_expect("t5_byte", 8'h81);
    step(FRAME);

    // 6: full FIFO, pop edge coincides with a push attempt
    d6[0] = 8'hD0; d6[1] = 8'hD1; d6[2] = 8'hD2; d6[3] = 8'hD3; d6[4] = 8'hD4;
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(d6[i]);
    step(2);
    chk("t6_full", 32'(fifo_count), 32'd4);
    en       = 1'b1;
    tx_valid = 1'b1;
    tx_byte  = d6[4];
    step(1);
    chk("t6_pop_count", 32'(fifo_count), 32'd3);
    chk("t6_pop_ready", 32'(tx_ready), 32'd1);
    step(1);
    chk("t6_refill_count", 32'(fifo_count), 32'd4);
    chk("t6_refill_ready", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) rx_expect("t6_order", d6[i]);
    step(FRAME);

    // Random traffic with varying push rate and occasional en toggles
    rate = 5;
    for (int i = 0; i < 12000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 1;
          1:       rate = 5;
          default: rate = 30;
        endcase
      end
      tx_valid = ($urandom_range(0, 99) < rate);
      tx_byte  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) en = ~en;
      step(1);
    end
    tx_valid = 1'b0;
    en       = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      step(1);
      if (!m_busy) break;
    end
    step(2);
    chk("final_idle_busy", 32'(tx_busy), 32'd0);
    chk("final_idle_tx", 32'(tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
